// File: rtl/mac_bank_seq.sv
// Tile sequencer for the 12-lane MAC bank: issues buffer reads, re-times the read strobe
// through the buffer and bank latencies, then drives bias-add and the output handshake.
module mac_bank_seq #(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 10,
  parameter int RD_LAT  = 2,
  parameter int MAC_LAT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  cfg_ntile_i,
  input  logic [ADDR_W-1:0] cfg_din_base_i,
  input  logic [ADDR_W-1:0] cfg_wgt_base_i,
  input  logic              out_rdy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              din_rd_en_o,
  output logic [ADDR_W-1:0] din_addr_o,
  output logic              wgt_rd_en_o,
  output logic [ADDR_W-1:0] wgt_addr_o,
  output logic              mac_vld_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              bias_en_o,
  output logic              out_vld_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    BIAS,
    OUT,
    DONE
  } state_t;

  // Every pipe stage except the last (acc_en) stage must be empty to leave DRAIN.
  localparam logic [MAC_LAT-1:0] MAC_LOW_MASK = {MAC_LAT{1'b1}} >> 1;

  state_t              stateReg, stateNext;
  logic [CNT_W-1:0]    tileCntReg;
  logic [CNT_W-1:0]    ntileReg;
  logic [ADDR_W-1:0]   dinAddrReg;
  logic [ADDR_W-1:0]   wgtAddrReg;
  logic [RD_LAT-1:0]   rdPipeReg, rdPipeNext;
  logic [MAC_LAT-1:0]  macPipeReg, macPipeNext;
  logic                firstReg;
  logic                rdEn;
  logic                accEn;
  logic                lastRead;
  logic                pipeDrained;
  logic                startJob;

  assign rdEn        = (stateReg == ISSUE);
  assign accEn       = macPipeReg[MAC_LAT-1];
  assign lastRead    = (tileCntReg == (ntileReg - CNT_W'(1)));
  assign pipeDrained = (rdPipeReg == '0) && ((macPipeReg & MAC_LOW_MASK) == '0);
  assign startJob    = (stateReg == IDLE) && start_i;

  assign rdPipeNext[0]  = rdEn;
  assign macPipeNext[0] = rdPipeReg[RD_LAT-1];

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rdPipe
    assign rdPipeNext[gi] = rdPipeReg[gi-1];
  end

  for (genvar gi = 1; gi < MAC_LAT; gi++) begin : g_macPipe
    assign macPipeNext[gi] = macPipeReg[gi-1];
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE:    if (start_i) stateNext = (cfg_ntile_i != '0) ? ISSUE : DONE;
      ISSUE:   if (lastRead) stateNext = DRAIN;
      DRAIN:   if (pipeDrained) stateNext = BIAS;
      BIAS:    stateNext = OUT;
      OUT:     if (out_rdy_i) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      stateReg   <= IDLE;
      tileCntReg <= '0;
      ntileReg   <= '0;
      dinAddrReg <= '0;
      wgtAddrReg <= '0;
      rdPipeReg  <= '0;
      macPipeReg <= '0;
      firstReg   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      rdPipeReg  <= rdPipeNext;
      macPipeReg <= macPipeNext;
      if (startJob && (cfg_ntile_i != '0)) begin
        ntileReg   <= cfg_ntile_i;
        tileCntReg <= '0;
        dinAddrReg <= cfg_din_base_i;
        wgtAddrReg <= cfg_wgt_base_i;
        firstReg   <= 1'b1;
      end else begin
        // Addresses stop on the last read so they hold base+N-1 after ISSUE.
        if (rdEn && !lastRead) begin
          tileCntReg <= tileCntReg + CNT_W'(1);
          dinAddrReg <= dinAddrReg + ADDR_W'(1);
          wgtAddrReg <= wgtAddrReg + ADDR_W'(1);
        end
        if (accEn) firstReg <= 1'b0;
      end
    end
  end

  // busy_o falls in the done_o cycle, so a new start is accepted right after it.
  assign busy_o      = (stateReg != IDLE) && (stateReg != DONE);
  assign done_o      = (stateReg == DONE);
  assign din_rd_en_o = rdEn;
  assign wgt_rd_en_o = rdEn;
  assign din_addr_o  = dinAddrReg;
  assign wgt_addr_o  = wgtAddrReg;
  assign mac_vld_o   = rdPipeReg[RD_LAT-1];
  assign acc_en_o    = accEn;
  assign acc_clr_o   = accEn & firstReg;
  assign bias_en_o   = (stateReg == BIAS);
  assign out_vld_o   = (stateReg == OUT);

endmodule

// File: tb/tb_mac_bank_seq.sv
// Directed bench for mac_bank_seq: per-cycle strobe maps (bit c = cycle c after the start cycle)
// are compared against hand-derived masks.
module tb_mac_bank_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_i;
  logic [9:0] cfg_ntile_i;
  logic [9:0] cfg_din_base_i;
  logic [9:0] cfg_wgt_base_i;
  logic       out_rdy_i;
  logic       busy_o, done_o, din_rd_en_o, wgt_rd_en_o, mac_vld_o;
  logic       acc_clr_o, acc_en_o, bias_en_o, out_vld_o;
  logic [9:0] din_addr_o, wgt_addr_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] rdV, wrdV, mvV, aeV, acV, beV, ovV, dnV, bsV;
  logic [9:0]  dinA[64];
  logic [9:0]  wgtA[64];

  always #5 clk = ~clk;

  mac_bank_seq dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .cfg_ntile_i(cfg_ntile_i),
    .cfg_din_base_i(cfg_din_base_i), .cfg_wgt_base_i(cfg_wgt_base_i), .out_rdy_i(out_rdy_i),
    .busy_o(busy_o), .done_o(done_o), .din_rd_en_o(din_rd_en_o), .din_addr_o(din_addr_o),
    .wgt_rd_en_o(wgt_rd_en_o), .wgt_addr_o(wgt_addr_o), .mac_vld_o(mac_vld_o),
    .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o), .bias_en_o(bias_en_o), .out_vld_o(out_vld_o)
  );

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Records every output for ncyc cycles while replaying start/reset masks and out_rdy.
  task automatic capture(input logic [63:0] startMask, input logic [63:0] rstMask,
                         input int rdyFrom, input int cfgChgAt, input int ncyc);
    rdV = '0; wrdV = '0; mvV = '0; aeV = '0; acV = '0; beV = '0; ovV = '0; dnV = '0; bsV = '0;
    for (int c = 0; c < ncyc; c++) begin
      rdV[c] = din_rd_en_o;  wrdV[c] = wgt_rd_en_o; mvV[c] = mac_vld_o;
      aeV[c] = acc_en_o;     acV[c] = acc_clr_o;    beV[c] = bias_en_o;
      ovV[c] = out_vld_o;    dnV[c] = done_o;       bsV[c] = busy_o;
      dinA[c] = din_addr_o;  wgtA[c] = wgt_addr_o;
      start_i   = startMask[c];
      rstn      = rstMask[c];
      out_rdy_i = (c >= rdyFrom);
      if (c == cfgChgAt) begin
        cfg_ntile_i = 10'd2; cfg_din_base_i = 10'h100; cfg_wgt_base_i = 10'h300;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    rstn    = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1; start_i = 1'b1; out_rdy_i = 1'b0;
    cfg_ntile_i = 10'd3; cfg_din_base_i = 10'h010; cfg_wgt_base_i = 10'h200;
    idle(3);
    checks++;
    if ({busy_o, done_o, din_rd_en_o, wgt_rd_en_o, mac_vld_o, acc_clr_o, acc_en_o, bias_en_o, out_vld_o} !== 9'b0) begin
      errors++; $display("FAIL reset_strobes actual=%b required=0", {busy_o, done_o, din_rd_en_o, wgt_rd_en_o,
                         mac_vld_o, acc_clr_o, acc_en_o, bias_en_o, out_vld_o});
    end
    checks++;
    if (din_addr_o !== 10'h000) begin errors++; $display("FAIL reset_din_addr actual=%h required=000", din_addr_o); end
    checks++;
    if (wgt_addr_o !== 10'h000) begin errors++; $display("FAIL reset_wgt_addr actual=%h required=000", wgt_addr_o); end
    start_i = 1'b0; rstn = 1'b0;
    idle(2);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy actual=%b required=0", busy_o); end
    $display("test_reset: done");
  endtask

  task automatic test_basic(input string tag);
    cfg_ntile_i = 10'd3; cfg_din_base_i = 10'h010; cfg_wgt_base_i = 10'h200;
    capture(64'h1, 64'h0, 0, -1, 16);
    checks++; if (rdV !== 64'h000E) begin errors++; $display("FAIL %s rd_en actual=%h required=000e", tag, rdV); end
    checks++; if (wrdV !== 64'h000E) begin errors++; $display("FAIL %s wgt_rd_en actual=%h required=000e", tag, wrdV); end
    checks++; if (mvV !== 64'h0038) begin errors++; $display("FAIL %s mac_vld actual=%h required=0038", tag, mvV); end
    checks++; if (aeV !== 64'h0380) begin errors++; $display("FAIL %s acc_en actual=%h required=0380", tag, aeV); end
    checks++; if (acV !== 64'h0080) begin errors++; $display("FAIL %s acc_clr actual=%h required=0080", tag, acV); end
    checks++; if (beV !== 64'h0400) begin errors++; $display("FAIL %s bias_en actual=%h required=0400", tag, beV); end
    checks++; if (ovV !== 64'h0800) begin errors++; $display("FAIL %s out_vld actual=%h required=0800", tag, ovV); end
    checks++; if (dnV !== 64'h1000) begin errors++; $display("FAIL %s done actual=%h required=1000", tag, dnV); end
    checks++; if (bsV !== 64'h0FFE) begin errors++; $display("FAIL %s busy actual=%h required=0ffe", tag, bsV); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dinA[k+1] !== 10'h010 + 10'(k)) begin
        errors++; $display("FAIL %s din_addr[%0d] actual=%h required=%h", tag, k, dinA[k+1], 10'h010 + 10'(k));
      end
      checks++;
      if (wgtA[k+1] !== 10'h200 + 10'(k)) begin
        errors++; $display("FAIL %s wgt_addr[%0d] actual=%h required=%h", tag, k, wgtA[k+1], 10'h200 + 10'(k));
      end
    end
    $display("%s: N=3 job captured", tag);
    idle(2);
  endtask

  task automatic test_backpressure;
    cfg_ntile_i = 10'd1; cfg_din_base_i = 10'h005; cfg_wgt_base_i = 10'h006;
    capture(64'h1, 64'h0, 14, -1, 20);
    checks++; if (rdV !== 64'h0002) begin errors++; $display("FAIL bp rd_en actual=%h required=0002", rdV); end
    checks++; if (aeV !== 64'h0080) begin errors++; $display("FAIL bp acc_en actual=%h required=0080", aeV); end
    checks++; if (acV !== 64'h0080) begin errors++; $display("FAIL bp acc_clr actual=%h required=0080", acV); end
    checks++; if (beV !== 64'h0100) begin errors++; $display("FAIL bp bias_en actual=%h required=0100", beV); end
    checks++; if (ovV !== 64'h7E00) begin errors++; $display("FAIL bp out_vld actual=%h required=7e00", ovV); end
    checks++; if (dnV !== 64'h8000) begin errors++; $display("FAIL bp done actual=%h required=8000", dnV); end
    checks++; if (bsV !== 64'h7FFE) begin errors++; $display("FAIL bp busy actual=%h required=7ffe", bsV); end
    $display("test_backpressure: N=1 job captured");
    idle(2);
  endtask

  task automatic test_zero_tiles;
    cfg_ntile_i = 10'd0; cfg_din_base_i = 10'h050; cfg_wgt_base_i = 10'h060;
    capture(64'h1, 64'h0, 0, -1, 12);
    checks++; if (dnV !== 64'h0002) begin errors++; $display("FAIL zero done actual=%h required=0002", dnV); end
    checks++;
    if ((rdV | mvV | aeV | beV | ovV | bsV) !== 64'h0) begin
      errors++; $display("FAIL zero strobes actual=%h required=0", rdV | mvV | aeV | beV | ovV | bsV);
    end
    $display("test_zero_tiles: N=0 job captured");
    idle(2);
  endtask

  task automatic test_addr_wrap;
    logic [9:0] expA[4];
    expA = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    cfg_ntile_i = 10'd4; cfg_din_base_i = 10'h3FE; cfg_wgt_base_i = 10'h000;
    capture(64'h1, 64'h0, 0, -1, 16);
    checks++; if (rdV !== 64'h001E) begin errors++; $display("FAIL wrap rd_en actual=%h required=001e", rdV); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dinA[k+1] !== expA[k]) begin
        errors++; $display("FAIL wrap din_addr[%0d] actual=%h required=%h", k, dinA[k+1], expA[k]);
      end
    end
    checks++; if (dinA[7] !== 10'h001) begin errors++; $display("FAIL wrap addr_hold actual=%h required=001", dinA[7]); end
    $display("test_addr_wrap: N=4 job captured");
    idle(2);
  endtask

  task automatic test_back_to_back;
    cfg_ntile_i = 10'd3; cfg_din_base_i = 10'h010; cfg_wgt_base_i = 10'h200;
    capture(64'h3005, 64'h0, 0, 2, 24);
    checks++; if (rdV !== 64'hC00E) begin errors++; $display("FAIL b2b rd_en actual=%h required=c00e", rdV); end
    checks++; if (mvV !== 64'h30038) begin errors++; $display("FAIL b2b mac_vld actual=%h required=30038", mvV); end
    checks++; if (aeV !== 64'h300380) begin errors++; $display("FAIL b2b acc_en actual=%h required=300380", aeV); end
    checks++; if (acV !== 64'h100080) begin errors++; $display("FAIL b2b acc_clr actual=%h required=100080", acV); end
    checks++; if (beV !== 64'h400400) begin errors++; $display("FAIL b2b bias_en actual=%h required=400400", beV); end
    checks++; if (ovV !== 64'h800800) begin errors++; $display("FAIL b2b out_vld actual=%h required=800800", ovV); end
    checks++; if (dnV !== 64'h1000) begin errors++; $display("FAIL b2b done actual=%h required=1000", dnV); end
    checks++; if (bsV !== 64'hFFCFFE) begin errors++; $display("FAIL b2b busy actual=%h required=ffcffe", bsV); end
    checks++; if (dinA[3] !== 10'h012) begin errors++; $display("FAIL b2b din_addr2 actual=%h required=012", dinA[3]); end
    checks++; if (dinA[14] !== 10'h100) begin errors++; $display("FAIL b2b job2_din0 actual=%h required=100", dinA[14]); end
    checks++; if (wgtA[15] !== 10'h301) begin errors++; $display("FAIL b2b job2_wgt1 actual=%h required=301", wgtA[15]); end
    $display("test_back_to_back: two jobs captured");
    idle(4);
  endtask

  task automatic test_reset_abort;
    cfg_ntile_i = 10'd3; cfg_din_base_i = 10'h010; cfg_wgt_base_i = 10'h200;
    capture(64'h1, 64'h20, 0, -1, 16);
    checks++; if (rdV !== 64'h000E) begin errors++; $display("FAIL abort rd_en actual=%h required=000e", rdV); end
    checks++; if (mvV !== 64'h0038) begin errors++; $display("FAIL abort mac_vld actual=%h required=0038", mvV); end
    checks++;
    if ((aeV | acV | beV | ovV | dnV) !== 64'h0) begin
      errors++; $display("FAIL abort late_strobes actual=%h required=0", aeV | acV | beV | ovV | dnV);
    end
    checks++; if (bsV !== 64'h003E) begin errors++; $display("FAIL abort busy actual=%h required=003e", bsV); end
    checks++; if (dinA[6] !== 10'h000) begin errors++; $display("FAIL abort din_addr actual=%h required=000", dinA[6]); end
    $display("test_reset_abort: aborted job captured");
    idle(2);
    test_basic("after_abort");
  endtask

  task automatic test_max_tiles;
    int rdCount = 0;
    int firstRd = -1;
    int lastRd  = -1;
    int doneAt  = -1;
    cfg_ntile_i = 10'h3FF; cfg_din_base_i = 10'h000; cfg_wgt_base_i = 10'h000;
    out_rdy_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c < 1200 && doneAt < 0; c++) begin
      if (din_rd_en_o) begin rdCount++; if (firstRd < 0) firstRd = c; lastRd = c; end
      if (done_o) doneAt = c;
      @(posedge clk); #1;
    end
    checks++; if (rdCount !== 1023) begin errors++; $display("FAIL max rd_count actual=%0d required=1023", rdCount); end
    checks++; if (firstRd !== 1) begin errors++; $display("FAIL max first_rd actual=%0d required=1", firstRd); end
    checks++; if (lastRd !== 1023) begin errors++; $display("FAIL max last_rd actual=%0d required=1023", lastRd); end
    checks++; if (doneAt !== 1032) begin errors++; $display("FAIL max done_cycle actual=%0d required=1032", doneAt); end
    $display("test_max_tiles: N=1023 job observed");
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_backpressure();
    test_zero_tiles();
    test_addr_wrap();
    test_back_to_back();
    test_reset_abort();
    test_max_tiles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
